collision_speed_arbiter: RTL and testbench
==========================================

COLLISION_SPEED_ARBITER -- requirements
Module: collision_speed_arbiter

Interface
REQ-001 SHALL have parameter NUM_BALLS, default 4; number of balls served.
REQ-002 SHALL have parameter CALC_TIMEOUT, default 255; maximum cycles to wait for calc_done.
REQ-003 SHALL derive NUM_PAIRS = NUM_BALLS*(NUM_BALLS-1)/2 (6 at default) and PAIR_W = clog2(NUM_PAIRS).
REQ-004 clk  in  1  system clock.
REQ-005 resetN  in  1  reset, asynchronous, active-low.
REQ-006 startOfFrame  in  1  one-cycle pulse at each frame start.
REQ-007 pair_collision  in  NUM_PAIRS  level; bit p set while the balls of pair p overlap.
REQ-008 ball_xspeed, ball_yspeed  in  NUM_BALLS x 11 signed  current speed of each ball.
REQ-009 calc_start  out  1  one-cycle pulse that launches the shared speed-calculation unit.
REQ-010 calc_ax, calc_ay, calc_bx, calc_by  out  11 signed each  operand speeds of ball A and ball B; held stable from calc_start until calc_done.
REQ-011 calc_done  in  1  one-cycle pulse; calc_xa, calc_ya, calc_xb, calc_yb are valid in that cycle.
REQ-012 calc_xa, calc_ya, calc_xb, calc_yb  in  11 signed each  post-collision speeds.
REQ-013 collision_with_ball  out  NUM_BALLS  one-cycle pulse per ball receiving new speed.
REQ-014 Xspeed_out, Yspeed_out  out  NUM_BALLS x 11 signed  registered new speeds; valid in the pulse cycle and held afterwards.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 calc_timeout_err  out  1  sticky; set on timeout, cleared only by reset.

Function
REQ-017 Pair p SHALL map to balls (i,j) with i<j, enumerated lexicographically: 0=(0,1), 1=(0,2), 2=(0,3), 3=(1,2), 4=(1,3), 5=(2,3); i is A and j is B.
REQ-018 pending[p] SHALL be set in the cycle after pair_collision[p]=1, unless served[p]=1.
REQ-019 States SHALL be IDLE, SELECT, CALC and APPLY.
REQ-020 IDLE->SELECT SHALL occur when pending is nonzero.
REQ-021 SELECT SHALL pick the lowest pending index at or after rr_ptr, wrapping modulo NUM_PAIRS. In the same cycle it SHALL register the operands from ball_x/yspeed, pulse calc_start and go to CALC.
REQ-022 CALC SHALL wait for calc_done, then capture the results and go to APPLY.
REQ-023 APPLY SHALL last one cycle and do all of the following: pulse collision_with_ball[i] and collision_with_ball[j]; update Xspeed_out/Yspeed_out for i and j; clear pending[p]; set served[p]; set rr_ptr=(p+1) mod NUM_PAIRS; go to IDLE.
REQ-024 Latency: request sampled at cycle N gives calc_start at N+2 when IDLE. A calc_done at cycle D gives the collision pulse at D+1.
REQ-025 Each pair SHALL be served at most once per frame.
REQ-026 startOfFrame SHALL clear served and pending. If pair_collision is high in that same cycle, the pending bit SHALL be set for the new frame.
REQ-027 An in-flight calculation SHALL complete and be applied across startOfFrame, and that pair's served bit SHALL then be set for the new frame.
REQ-028 A calc_done that arrives outside CALC SHALL be ignored.
REQ-029 If CALC lasts CALC_TIMEOUT cycles without calc_done, the block SHALL do all of the following: clear pending[p]; set served[p]; set calc_timeout_err; return to IDLE; emit no pulse.
REQ-030 Balls not in the served pair SHALL keep their Xspeed_out/Yspeed_out unchanged.
REQ-031 Speeds SHALL pass through unmodified at 11-bit signed width, with no saturation or scaling.

Reset
REQ-032 Reset SHALL set state=IDLE and rr_ptr=0, and clear pending, served and the timeout counter.
REQ-033 Reset SHALL drive to 0: calc_start, collision_with_ball, all Xspeed_out/Yspeed_out, all calc operands, busy and calc_timeout_err.
REQ-034 Reset asserted mid-CALC SHALL abandon the calculation, and a later calc_done SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold the state enum, the default NUM_BALLS, a pair-to-(i,j) lookup function and the speed width constant (11).
REQ-036 The module SHALL instantiate one sub-module, rr_pair_picker, which is combinational: inputs pending and rr_ptr; outputs the valid flag and the index.

Verification
REQ-037 Single request: pair 0 at cycle 10 with ball0=(+20,0) and ball1=(0,0), unit done 4 cycles after start returning A=(0,0) and B=(20,0) -> calc_start at 12, pulses on balls 0 and 1 at 17, Xspeed_out[1]=20.
REQ-038 Simultaneous pairs 1 and 4 with rr_ptr=2 -> pair 4 served first, then pair 1, giving two separate pulse cycles.
REQ-039 pair_collision[0] held high for a whole frame -> exactly one service; after startOfFrame it is served once again.
REQ-040 calc_done withheld -> after 255 cycles in CALC: calc_timeout_err=1, no pulse, next pending pair served.
REQ-041 startOfFrame during CALC -> result applied; the same pair, still overlapping, is not re-served in the new frame.
REQ-042 resetN low mid-CALC, then a late calc_done -> all outputs 0, no pulse, busy=0.

Source files
------------

// File: rtl/collision_speed_arbiter_pkg.sv
// Shared types and helpers for the collision speed arbiter: FSM states,
// speed width and the pair-index to ball-pair mapping.
package collision_speed_arbiter_pkg;

  localparam int unsigned SPEED_W           = 11;
  localparam int unsigned DEFAULT_NUM_BALLS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    CALC   = 2'd2,
    APPLY  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } ball_pair_t;

  // Pairs (i,j), i<j, enumerated lexicographically; i is ball A, j is ball B
  function automatic ball_pair_t pair_to_balls(input int unsigned num_balls,
                                               input int unsigned pair);
    ball_pair_t  res;
    int unsigned p;
    res = '0;
    p   = 0;
    for (int unsigned i = 0; i < num_balls; i++) begin
      for (int unsigned j = i + 1; j < num_balls; j++) begin
        if (p == pair) begin
          res.a = 8'(i);
          res.b = 8'(j);
        end
        p++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/collision_speed_arbiter_rr_pair_picker.sv
// Combinational round-robin picker: lowest pending pair index at or after
// rr_ptr, wrapping modulo NUM_PAIRS.
module rr_pair_picker #(
  parameter int unsigned NUM_PAIRS = 6,
  parameter int unsigned PAIR_W    = 3
) (
  input  logic [NUM_PAIRS-1:0] pending,
  input  logic [PAIR_W-1:0]    rr_ptr,
  output logic                 valid_c,
  output logic [PAIR_W-1:0]    idx_c
);

  // Scan offsets from farthest to nearest so the nearest hit wins
  always_comb begin
    int unsigned cand;
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = 0;
    for (int unsigned k = NUM_PAIRS; k > 0; k--) begin
      cand = (32'(rr_ptr) + k - 1) % NUM_PAIRS;
      if (pending[PAIR_W'(cand)]) begin
        valid_c = 1'b1;
        idx_c   = PAIR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/collision_speed_arbiter.sv
// Serialises ball-pair collisions onto one shared speed-calculation unit and
// applies the returned speeds, serving each pair at most once per frame.
module collision_speed_arbiter
  import collision_speed_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_BALLS    = DEFAULT_NUM_BALLS,
  parameter  int unsigned CALC_TIMEOUT = 255,
  localparam int unsigned NUM_PAIRS    = NUM_BALLS * (NUM_BALLS - 1) / 2
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      startOfFrame,
  input  logic [NUM_PAIRS-1:0]      pair_collision,
  input  logic signed [SPEED_W-1:0] ball_xspeed [NUM_BALLS],
  input  logic signed [SPEED_W-1:0] ball_yspeed [NUM_BALLS],
  output logic                      calc_start,
  output logic signed [SPEED_W-1:0] calc_ax,
  output logic signed [SPEED_W-1:0] calc_ay,
  output logic signed [SPEED_W-1:0] calc_bx,
  output logic signed [SPEED_W-1:0] calc_by,
  input  logic                      calc_done,
  input  logic signed [SPEED_W-1:0] calc_xa,
  input  logic signed [SPEED_W-1:0] calc_ya,
  input  logic signed [SPEED_W-1:0] calc_xb,
  input  logic signed [SPEED_W-1:0] calc_yb,
  output logic [NUM_BALLS-1:0]      collision_with_ball,
  output logic signed [SPEED_W-1:0] Xspeed_out [NUM_BALLS],
  output logic signed [SPEED_W-1:0] Yspeed_out [NUM_BALLS],
  output logic                      busy,
  output logic                      calc_timeout_err
);

  localparam int unsigned PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int unsigned BALL_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam int unsigned TMO_W  = $clog2(CALC_TIMEOUT + 1);

  state_t                    state_q, state_n;
  logic [NUM_PAIRS-1:0]      pending_q, pending_n;
  logic [NUM_PAIRS-1:0]      served_q, served_n;
  logic [PAIR_W-1:0]         rr_ptr_q, rr_ptr_n;
  logic [PAIR_W-1:0]         sel_q, sel_n;
  logic [TMO_W-1:0]          tmo_q, tmo_n;
  logic                      start_n, busy_n, err_n;
  logic [NUM_BALLS-1:0]      coll_n;
  logic signed [SPEED_W-1:0] ax_n, ay_n, bx_n, by_n;
  logic signed [SPEED_W-1:0] xs_n [NUM_BALLS];
  logic signed [SPEED_W-1:0] ys_n [NUM_BALLS];
  logic                      pick_valid_c;
  logic [PAIR_W-1:0]         pick_idx_c;
  ball_pair_t                pick_ab, sel_ab;

  rr_pair_picker #(
    .NUM_PAIRS (NUM_PAIRS),
    .PAIR_W    (PAIR_W)
  ) u_picker (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  assign pick_ab = pair_to_balls(NUM_BALLS, 32'(pick_idx_c));
  assign sel_ab  = pair_to_balls(NUM_BALLS, 32'(sel_q));

  // Next-state and next-output logic. The pick is made while IDLE so that
  // calc_start and its operands appear together in the SELECT cycle.
  always_comb begin
    state_n  = state_q;
    served_n = startOfFrame ? '0 : served_q;
    pending_n = (startOfFrame ? '0 : pending_q) | (pair_collision & ~served_n);
    rr_ptr_n = rr_ptr_q;
    sel_n    = sel_q;
    tmo_n    = tmo_q;
    start_n  = 1'b0;
    coll_n   = '0;
    ax_n     = calc_ax;
    ay_n     = calc_ay;
    bx_n     = calc_bx;
    by_n     = calc_by;
    xs_n     = Xspeed_out;
    ys_n     = Yspeed_out;
    err_n    = calc_timeout_err;

    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_n = SELECT;
          sel_n   = pick_idx_c;
          start_n = 1'b1;
          ax_n    = ball_xspeed[BALL_W'(pick_ab.a)];
          ay_n    = ball_yspeed[BALL_W'(pick_ab.a)];
          bx_n    = ball_xspeed[BALL_W'(pick_ab.b)];
          by_n    = ball_yspeed[BALL_W'(pick_ab.b)];
        end
      end
      SELECT: begin
        state_n = CALC;
        tmo_n   = '0;
      end
      CALC: begin
        if (calc_done) begin
          state_n                      = APPLY;
          coll_n[BALL_W'(sel_ab.a)]    = 1'b1;
          coll_n[BALL_W'(sel_ab.b)]    = 1'b1;
          xs_n[BALL_W'(sel_ab.a)]      = calc_xa;
          ys_n[BALL_W'(sel_ab.a)]      = calc_ya;
          xs_n[BALL_W'(sel_ab.b)]      = calc_xb;
          ys_n[BALL_W'(sel_ab.b)]      = calc_yb;
        end else if (tmo_q == TMO_W'(CALC_TIMEOUT - 1)) begin
          state_n          = IDLE;
          pending_n[sel_q] = 1'b0;
          served_n[sel_q]  = 1'b1;
          err_n            = 1'b1;
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end
      APPLY: begin
        state_n          = IDLE;
        pending_n[sel_q] = 1'b0;
        served_n[sel_q]  = 1'b1;
        rr_ptr_n = (sel_q == PAIR_W'(NUM_PAIRS - 1)) ? '0 : sel_q + PAIR_W'(1);
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q             <= IDLE;
      pending_q           <= '0;
      served_q            <= '0;
      rr_ptr_q            <= '0;
      sel_q               <= '0;
      tmo_q               <= '0;
      calc_start          <= 1'b0;
      calc_ax             <= '0;
      calc_ay             <= '0;
      calc_bx             <= '0;
      calc_by             <= '0;
      collision_with_ball <= '0;
      Xspeed_out          <= '{default: '0};
      Yspeed_out          <= '{default: '0};
      busy                <= 1'b0;
      calc_timeout_err    <= 1'b0;
    end else begin
      state_q             <= state_n;
      pending_q           <= pending_n;
      served_q            <= served_n;
      rr_ptr_q            <= rr_ptr_n;
      sel_q               <= sel_n;
      tmo_q               <= tmo_n;
      calc_start          <= start_n;
      calc_ax             <= ax_n;
      calc_ay             <= ay_n;
      calc_bx             <= bx_n;
      calc_by             <= by_n;
      collision_with_ball <= coll_n;
      Xspeed_out          <= xs_n;
      Yspeed_out          <= ys_n;
      busy                <= busy_n;
      calc_timeout_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_collision_speed_arbiter.sv
// Directed self-checking bench for collision_speed_arbiter with 4 balls
// and the default calculation timeout.
module tb_collision_speed_arbiter;

  logic              clk;
  logic              resetN;
  logic              startOfFrame;
  logic [5:0]        pair_collision;
  logic signed [10:0] bxs [4];
  logic signed [10:0] bys [4];
  logic              calc_start;
  logic signed [10:0] calc_ax, calc_ay, calc_bx, calc_by;
  logic              calc_done;
  logic signed [10:0] calc_xa, calc_ya, calc_xb, calc_yb;
  logic [3:0]        collision_with_ball;
  logic signed [10:0] xs_out [4];
  logic signed [10:0] ys_out [4];
  logic              busy;
  logic              calc_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  collision_speed_arbiter #(
    .NUM_BALLS    (4),
    .CALC_TIMEOUT (255)
  ) dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .pair_collision      (pair_collision),
    .ball_xspeed         (bxs),
    .ball_yspeed         (bys),
    .calc_start          (calc_start),
    .calc_ax             (calc_ax),
    .calc_ay             (calc_ay),
    .calc_bx             (calc_bx),
    .calc_by             (calc_by),
    .calc_done           (calc_done),
    .calc_xa             (calc_xa),
    .calc_ya             (calc_ya),
    .calc_xb             (calc_xb),
    .calc_yb             (calc_yb),
    .collision_with_ball (collision_with_ball),
    .Xspeed_out          (xs_out),
    .Yspeed_out          (ys_out),
    .busy                (busy),
    .calc_timeout_err    (calc_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".start"}, 32'(calc_start), 0);
    chk({tag, ".coll"}, 32'(collision_with_ball), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".err"}, 32'(calc_timeout_err), 0);
    chk({tag, ".ax"}, 32'(calc_ax), 0);
    chk({tag, ".ay"}, 32'(calc_ay), 0);
    chk({tag, ".bx"}, 32'(calc_bx), 0);
    chk({tag, ".by"}, 32'(calc_by), 0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s.xs%0d", tag, b), 32'(xs_out[2'(b)]), 0);
      chk($sformatf("%s.ys%0d", tag, b), 32'(ys_out[2'(b)]), 0);
    end
  endtask

  // Wait (bounded) for calc_start, check operands, answer 4 cycles later,
  // and check the pulse one cycle after calc_done. Returns in the pulse cycle.
  task automatic run_calc(input string tag,
                          input int ax, input int ay, input int bx, input int by,
                          input int rax, input int ray, input int rbx, input int rby,
                          input int coll, input bit sof_mid);
    int waited;
    waited = 0;
    while (calc_start !== 1'b1 && waited < 40) begin
      tick(1);
      waited++;
    end
    chk({tag, ".start"}, 32'(calc_start), 1);
    chk({tag, ".ax"}, 32'(calc_ax), ax);
    chk({tag, ".ay"}, 32'(calc_ay), ay);
    chk({tag, ".bx"}, 32'(calc_bx), bx);
    chk({tag, ".by"}, 32'(calc_by), by);
    chk({tag, ".busy"}, 32'(busy), 1);
    tick(1);
    chk({tag, ".startpulse"}, 32'(calc_start), 0);
    if (sof_mid) startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(2);
    chk({tag, ".early"}, 32'(collision_with_ball), 0);
    calc_done = 1'b1;
    calc_xa   = 11'(rax);
    calc_ya   = 11'(ray);
    calc_xb   = 11'(rbx);
    calc_yb   = 11'(rby);
    tick(1);
    calc_done = 1'b0;
    chk({tag, ".pulse"}, 32'(collision_with_ball), coll);
  endtask

  initial begin
    int starts;
    int pulses;
    int waited;

    resetN         = 1'b0;
    startOfFrame   = 1'b0;
    pair_collision = '0;
    calc_done      = 1'b0;
    calc_xa = '0; calc_ya = '0; calc_xb = '0; calc_yb = '0;
    for (int b = 0; b < 4; b++) begin
      bxs[2'(b)] = '0;
      bys[2'(b)] = '0;
    end
    bxs[0] = 11'sd20;

    tick(3);
    check_zero("reset");
    resetN = 1'b1;
    tick(2);

    // Single request on pair 0: start two cycles later, pulse at done+1
    pair_collision = 6'b000001;
    tick(1);
    pair_collision = '0;
    chk("t1.n1_start", 32'(calc_start), 0);
    chk("t1.n1_busy", 32'(busy), 0);
    tick(1);
    chk("t1.n2_start", 32'(calc_start), 1);
    run_calc("t1", 20, 0, 0, 0, 0, 0, 20, 0, 3, 1'b0);
    chk("t1.xs1", 32'(xs_out[1]), 20);
    chk("t1.xs0", 32'(xs_out[0]), 0);
    tick(1);
    chk("t1.after_coll", 32'(collision_with_ball), 0);
    chk("t1.after_busy", 32'(busy), 0);
    chk("t1.hold_xs1", 32'(xs_out[1]), 20);

    bxs[0] = 11'sd5;   bys[0] = -11'sd3;
    bxs[1] = 11'sd7;   bys[1] = 11'sd2;
    bxs[2] = -11'sd9;  bys[2] = 11'sd4;
    bxs[3] = 11'sd100; bys[3] = -11'sd100;

    // Serve pair 1 alone to move the round-robin pointer to 2
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    pair_collision = 6'b000010;
    tick(1);
    pair_collision = '0;
    run_calc("t2a", 5, -3, -9, 4, 11, 12, 13, 14, 5, 1'b0);
    chk("t2a.xs1_kept", 32'(xs_out[1]), 20);
    chk("t2a.xs2", 32'(xs_out[2]), 13);
    chk("t2a.ys0", 32'(ys_out[0]), 12);
    tick(1);

    // Pairs 1 and 4 together with rr_ptr=2: pair 4 first, then pair 1
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    pair_collision = 6'b010010;
    tick(1);
    pair_collision = '0;
    run_calc("t2b", 7, 2, 100, -100, -1, -2, -3, -4, 10, 1'b0);
    chk("t2b.xs3", 32'(xs_out[3]), -3);
    chk("t2b.ys1", 32'(ys_out[1]), -2);
    chk("t2b.xs0_kept", 32'(xs_out[0]), 11);
    tick(1);
    chk("t2b.gap", 32'(collision_with_ball), 0);
    run_calc("t2c", 5, -3, -9, 4, 1023, -1024, 23, 24, 5, 1'b0);
    chk("t2c.xs0_max", 32'(xs_out[0]), 1023);
    chk("t2c.ys0_min", 32'(ys_out[0]), -1024);
    chk("t2c.xs3_kept", 32'(xs_out[3]), -3);
    tick(1);

    // Pair 0 held all frame: served once, then once more after startOfFrame
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    pair_collision = 6'b000001;
    run_calc("t3a", 5, -3, 7, 2, 31, 32, 33, 34, 3, 1'b0);
    chk("t3a.xs1", 32'(xs_out[1]), 33);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (calc_start) starts++;
    end
    chk("t3.once_per_frame", 32'(starts), 0);
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    run_calc("t3b", 5, -3, 7, 2, 41, 42, 43, 44, 3, 1'b0);
    chk("t3b.ys0", 32'(ys_out[0]), 42);
    chk("t3b.xs1", 32'(xs_out[1]), 43);
    pair_collision = '0;
    tick(1);

    // Pairs 2 and 3; pair 2 never answered and times out after 255 cycles
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    pair_collision = 6'b001100;
    tick(1);
    pair_collision = '0;
    waited = 0;
    while (calc_start !== 1'b1 && waited < 40) begin
      tick(1);
      waited++;
    end
    chk("t4.start", 32'(calc_start), 1);
    chk("t4.ax", 32'(calc_ax), 5);
    chk("t4.bx", 32'(calc_bx), 100);
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      tick(1);
      if (collision_with_ball != '0) pulses++;
    end
    chk("t4.err_before", 32'(calc_timeout_err), 0);
    chk("t4.busy_before", 32'(busy), 1);
    tick(1);
    chk("t4.err", 32'(calc_timeout_err), 1);
    chk("t4.busy_idle", 32'(busy), 0);
    chk("t4.coll", 32'(collision_with_ball), 0);
    chk("t4.no_pulse", 32'(pulses), 0);
    run_calc("t4b", 7, 2, -9, 4, 51, 52, 53, 54, 6, 1'b0);
    chk("t4b.xs1", 32'(xs_out[1]), 51);
    chk("t4b.xs2", 32'(xs_out[2]), 53);
    tick(1);

    // calc_done while IDLE is ignored
    calc_done = 1'b1;
    calc_xa = 11'sd333; calc_ya = 11'sd333; calc_xb = 11'sd333; calc_yb = 11'sd333;
    tick(1);
    calc_done = 1'b0;
    chk("t5.stray_coll", 32'(collision_with_ball), 0);
    chk("t5.stray_xs1", 32'(xs_out[1]), 51);
    chk("t5.stray_busy", 32'(busy), 0);
    tick(1);

    // startOfFrame during CALC: result applied, pair not re-served
    pair_collision = 6'b100000;
    run_calc("t6", -9, 4, 100, -100, 61, 62, 63, 64, 12, 1'b1);
    chk("t6.xs3", 32'(xs_out[3]), 63);
    chk("t6.ys2", 32'(ys_out[2]), 62);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (calc_start) starts++;
    end
    chk("t6.no_reserve", 32'(starts), 0);
    chk("t6.err_sticky", 32'(calc_timeout_err), 1);
    pair_collision = '0;
    tick(1);

    // Reset in the middle of CALC, then a late calc_done
    pair_collision = 6'b000001;
    tick(1);
    pair_collision = '0;
    waited = 0;
    while (calc_start !== 1'b1 && waited < 40) begin
      tick(1);
      waited++;
    end
    chk("t7.start", 32'(calc_start), 1);
    tick(2);
    resetN = 1'b0;
    #1;
    check_zero("t7.rst");
    tick(1);
    resetN = 1'b1;
    tick(1);
    calc_done = 1'b1;
    calc_xa = 11'sd77; calc_ya = 11'sd77; calc_xb = 11'sd77; calc_yb = 11'sd77;
    tick(1);
    calc_done = 1'b0;
    chk("t7.late_coll", 32'(collision_with_ball), 0);
    chk("t7.late_busy", 32'(busy), 0);
    chk("t7.late_xs0", 32'(xs_out[0]), 0);
    tick(2);
    chk("t7.idle_busy", 32'(busy), 0);
    chk("t7.idle_start", 32'(calc_start), 0);
    chk("t7.idle_coll", 32'(collision_with_ball), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
